// File: rtl/fifo_serializer_if.sv
// FIFO-read and bit-serial link bundle for fifo_serializer.
// master = serializer side, slave = FIFO/link side.
interface fifo_serializer_if #(
  parameter int DWIDTH = 16
);
  logic [DWIDTH-1:0] fifo_q_i;
  logic              fifo_empty_i;
  logic              fifo_rdreq_o;
  logic              ser_data_o;
  logic              ser_data_val_o;
  logic              ser_ready_i;
  logic              ser_last_o;
  logic              busy_o;

  modport master (
    input  fifo_q_i,
    input  fifo_empty_i,
    input  ser_ready_i,
    output fifo_rdreq_o,
    output ser_data_o,
    output ser_data_val_o,
    output ser_last_o,
    output busy_o
  );

  modport slave (
    output fifo_q_i,
    output fifo_empty_i,
    output ser_ready_i,
    input  fifo_rdreq_o,
    input  ser_data_o,
    input  ser_data_val_o,
    input  ser_last_o,
    input  busy_o
  );
endinterface

// File: rtl/fifo_serializer.sv
// Pops words from a show-ahead FIFO and shifts them out
// as a 1-bit valid/ready stream with no gap between words.
module fifo_serializer #(
  parameter int DWIDTH    = 16,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic               clk_i,
  input  logic               arstn_i,
  fifo_serializer_if.master  bus
);

  localparam int CW = $clog2(DWIDTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DWIDTH);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DWIDTH-1:0] r_sr;
  logic [DWIDTH-1:0] w_sr_nxt;
  logic [DWIDTH-1:0] w_shift;
  logic [CW-1:0]     r_cnt;
  logic [CW-1:0]     w_cnt_nxt;
  logic              w_acc;
  logic              w_pop;

  assign w_acc = (r_state == SHIFT) & bus.ser_ready_i;

  // Zero fill moves toward the end the bit is taken from.
  assign w_shift = MSB_FIRST ? {r_sr[DWIDTH-2:0], 1'b0}
                             : {1'b0, r_sr[DWIDTH-1:1]};

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      r_state <= IDLE;
      r_sr    <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sr    <= w_sr_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sr_nxt    = r_sr;
    w_cnt_nxt   = r_cnt;
    w_pop       = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_pop = !bus.fifo_empty_i;
        if (w_pop) begin
          w_sr_nxt    = bus.fifo_q_i;
          w_cnt_nxt   = FULL;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (w_acc) begin
          if (r_cnt == ONE) begin
            w_pop = !bus.fifo_empty_i;
            if (w_pop) begin
              w_sr_nxt  = bus.fifo_q_i;
              w_cnt_nxt = FULL;
            end else begin
              w_sr_nxt    = '0;
              w_cnt_nxt   = '0;
              w_state_nxt = IDLE;
            end
          end else begin
            w_sr_nxt  = w_shift;
            w_cnt_nxt = r_cnt - ONE;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign bus.fifo_rdreq_o   = arstn_i & w_pop;
  assign bus.ser_data_val_o = (r_state == SHIFT);
  assign bus.busy_o         = (r_state == SHIFT);
  assign bus.ser_last_o     = (r_state == SHIFT) & (r_cnt == ONE);
  assign bus.ser_data_o     = MSB_FIRST ? r_sr[DWIDTH-1] : r_sr[0];

endmodule

// File: tb/tb_fifo_serializer.sv
// Directed bench for fifo_serializer: MSB-first and
// LSB-first instances fed from queue-based FIFO models.
module tb_fifo_serializer;

  logic clk;
  logic arstn;

  fifo_serializer_if #(.DWIDTH(8)) a ();
  fifo_serializer_if #(.DWIDTH(8)) b ();

  fifo_serializer #(.DWIDTH(8), .MSB_FIRST(1'b1)) dut_a (
    .clk_i   (clk),
    .arstn_i (arstn),
    .bus     (a)
  );

  fifo_serializer #(.DWIDTH(8), .MSB_FIRST(1'b0)) dut_b (
    .clk_i   (clk),
    .arstn_i (arstn),
    .bus     (b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         push;
    logic [7:0] word;
    logic       rdy;
    logic       rd;
    logic       val;
    logic       dat;
    logic       last;
    logic       busy;
  } vec_t;

  vec_t       tv[$];
  logic [7:0] qa[$];
  logic [7:0] qb[$];
  int         checks;
  int         errors;

  logic s_rd, s_val, s_dat, s_last, s_busy;
  logic sb_rd, sb_val, sb_dat, sb_last;

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic refresh();
    a.fifo_empty_i = (qa.size() == 0);
    a.fifo_q_i     = (qa.size() != 0) ? qa[0] : 8'h00;
    b.fifo_empty_i = (qb.size() == 0);
    b.fifo_q_i     = (qb.size() != 0) ? qb[0] : 8'h00;
  endtask

  // Sample mid-cycle, pop on the edge, re-drive just after.
  task automatic cyc();
    @(negedge clk);
    s_rd   = a.fifo_rdreq_o;
    s_val  = a.ser_data_val_o;
    s_dat  = a.ser_data_o;
    s_last = a.ser_last_o;
    s_busy = a.busy_o;
    sb_rd  = b.fifo_rdreq_o;
    sb_val = b.ser_data_val_o;
    sb_dat = b.ser_data_o;
    sb_last = b.ser_last_o;
    @(posedge clk);
    if (s_rd && qa.size() != 0) void'(qa.pop_front());
    if (sb_rd && qb.size() != 0) void'(qb.pop_front());
    #1;
    refresh();
  endtask

  task automatic add(input bit p, input logic [7:0] w,
                     input logic r, input logic e_rd,
                     input logic e_val, input logic e_dat,
                     input logic e_last, input logic e_busy);
    vec_t v;
    v.push = p;
    v.word = w;
    v.rdy  = r;
    v.rd   = e_rd;
    v.val  = e_val;
    v.dat  = e_dat;
    v.last = e_last;
    v.busy = e_busy;
    tv.push_back(v);
  endtask

  task automatic check_all_zero(input string nm);
    chk({nm, "_val"},  {7'd0, a.ser_data_val_o}, 8'd0);
    chk({nm, "_busy"}, {7'd0, a.busy_o},         8'd0);
    chk({nm, "_dat"},  {7'd0, a.ser_data_o},     8'd0);
    chk({nm, "_last"}, {7'd0, a.ser_last_o},     8'd0);
    chk({nm, "_rd"},   {7'd0, a.fifo_rdreq_o},   8'd0);
  endtask

  initial begin
    int   rd_cnt;
    logic [7:0] w5a;
    checks = 0;
    errors = 0;
    arstn  = 1'b0;
    a.ser_ready_i = 1'b1;
    b.ser_ready_i = 1'b1;
    refresh();
    #2;
    check_all_zero("reset");

    // 0xA5 with ready held high
    add(1, 8'hA5, 1, 1, 0, 0, 0, 0);
    add(0, 8'h00, 1, 0, 1, 1, 0, 1);
    add(0, 8'h00, 1, 0, 1, 0, 0, 1);
    add(0, 8'h00, 1, 0, 1, 1, 0, 1);
    add(0, 8'h00, 1, 0, 1, 0, 0, 1);
    add(0, 8'h00, 1, 0, 1, 0, 0, 1);
    add(0, 8'h00, 1, 0, 1, 1, 0, 1);
    add(0, 8'h00, 1, 0, 1, 0, 0, 1);
    add(0, 8'h00, 1, 0, 1, 1, 1, 1);
    add(0, 8'h00, 1, 0, 0, 0, 0, 0);
    // 0xA5 with three stalled cycles on bit 3
    add(1, 8'hA5, 1, 1, 0, 0, 0, 0);
    add(0, 8'h00, 1, 0, 1, 1, 0, 1);
    add(0, 8'h00, 1, 0, 1, 0, 0, 1);
    add(0, 8'h00, 0, 0, 1, 1, 0, 1);
    add(0, 8'h00, 0, 0, 1, 1, 0, 1);
    add(0, 8'h00, 0, 0, 1, 1, 0, 1);
    add(0, 8'h00, 1, 0, 1, 1, 0, 1);
    add(0, 8'h00, 1, 0, 1, 0, 0, 1);
    add(0, 8'h00, 1, 0, 1, 0, 0, 1);
    add(0, 8'h00, 1, 0, 1, 1, 0, 1);
    add(0, 8'h00, 1, 0, 1, 0, 0, 1);
    add(0, 8'h00, 1, 0, 1, 1, 1, 1);
    add(0, 8'h00, 1, 0, 0, 0, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    arstn = 1'b1;

    // Empty FIFO after reset: nothing moves
    for (int i = 0; i < 20; i++) begin
      cyc();
      chk($sformatf("idle_rd%0d", i),
          {5'd0, s_rd, s_val, s_busy}, 8'd0);
    end

    // Data appears while reset is held
    arstn = 1'b0;
    qa.push_back(8'h12);
    refresh();
    #1;
    chk("rst_hold_rd", {7'd0, a.fifo_rdreq_o}, 8'd0);
    cyc();
    chk("rst_hold_rd_cyc", {7'd0, s_rd}, 8'd0);
    qa.delete();
    refresh();
    arstn = 1'b1;
    cyc();

    foreach (tv[i]) begin
      if (tv[i].push) begin
        qa.push_back(tv[i].word);
        refresh();
      end
      a.ser_ready_i = tv[i].rdy;
      cyc();
      chk($sformatf("tv%0d_rd", i),   {7'd0, s_rd},   {7'd0, tv[i].rd});
      chk($sformatf("tv%0d_val", i),  {7'd0, s_val},  {7'd0, tv[i].val});
      chk($sformatf("tv%0d_dat", i),  {7'd0, s_dat},  {7'd0, tv[i].dat});
      chk($sformatf("tv%0d_last", i), {7'd0, s_last}, {7'd0, tv[i].last});
      chk($sformatf("tv%0d_busy", i), {7'd0, s_busy}, {7'd0, tv[i].busy});
    end

    // 0xFF then 0x00 back to back
    a.ser_ready_i = 1'b1;
    qa.push_back(8'hFF);
    qa.push_back(8'h00);
    refresh();
    rd_cnt = 0;
    for (int c = 0; c < 18; c++) begin
      cyc();
      if (s_rd) rd_cnt++;
      chk($sformatf("b2b%0d_val", c), {7'd0, s_val},
          {7'd0, (c >= 1 && c <= 16)});
      chk($sformatf("b2b%0d_dat", c), {7'd0, s_dat},
          {7'd0, (c >= 1 && c <= 8)});
      chk($sformatf("b2b%0d_rd", c), {7'd0, s_rd},
          {7'd0, (c == 0 || c == 8)});
      chk($sformatf("b2b%0d_last", c), {7'd0, s_last},
          {7'd0, (c == 8 || c == 16)});
    end
    chk("b2b_rd_pulses", rd_cnt[7:0], 8'd2);

    // Reset after three bits of 0xC3, then 0x5A from its first bit
    qa.push_back(8'hC3);
    qa.push_back(8'h5A);
    refresh();
    cyc();
    chk("c3_rd", {7'd0, s_rd}, 8'd1);
    for (int c = 0; c < 3; c++) begin
      cyc();
      chk($sformatf("c3_bit%0d", c), {7'd0, s_dat},
          {7'd0, (c < 2)});
    end
    arstn = 1'b0;
    #1;
    check_all_zero("midrst");
    cyc();
    chk("midrst_hold_val", {7'd0, s_val}, 8'd0);
    arstn = 1'b1;
    cyc();
    chk("5a_rd", {7'd0, s_rd}, 8'd1);
    w5a = 8'h5A;
    for (int c = 0; c < 8; c++) begin
      cyc();
      chk($sformatf("5a_val%0d", c), {7'd0, s_val}, 8'd1);
      chk($sformatf("5a_dat%0d", c), {7'd0, s_dat},
          {7'd0, w5a[7-c]});
      chk($sformatf("5a_last%0d", c), {7'd0, s_last},
          {7'd0, (c == 7)});
    end
    cyc();
    chk("5a_done_val", {7'd0, s_val}, 8'd0);
    chk("5a_qempty", qa.size() == 0 ? 8'd1 : 8'd0, 8'd1);

    // LSB-first instance, word 0x01
    qb.push_back(8'h01);
    refresh();
    cyc();
    chk("lsb_rd", {7'd0, sb_rd}, 8'd1);
    for (int c = 0; c < 8; c++) begin
      cyc();
      chk($sformatf("lsb_val%0d", c), {7'd0, sb_val}, 8'd1);
      chk($sformatf("lsb_dat%0d", c), {7'd0, sb_dat},
          {7'd0, (c == 0)});
      chk($sformatf("lsb_last%0d", c), {7'd0, sb_last},
          {7'd0, (c == 7)});
    end
    cyc();
    chk("lsb_done_val", {7'd0, sb_val}, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
